// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit. Each accepted load or store
// becomes one request/acknowledge transaction on the data-memory bus.
// Loads are aligned and sign- or zero-extended into memory_data. The unit
// stalls the pipeline while a transaction is outstanding, rejects misaligned
// accesses and aborts a transaction when the ack does not arrive in time.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] memory_data,
    output logic        resp_valid,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_error
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // Counter value reached in the last cycle of BUSY before abort.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;

    logic        start;
    logic        aligned;
    logic        accept;
    logic        timeout_hit;
    logic        busy;

    logic [15:0] tmo_cnt;

    // Transaction context captured when an op is accepted.
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wstrb;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;

    // Store formatting for the op currently presented by execute.
    logic [31:0] wdata_nxt;
    logic [3:0]  wstrb_nxt;
    logic        we_nxt;

    // Pick the byte/half lane out of the returned word and extend it.
    function automatic logic [31:0] load_extract(
        input logic [2:0]  f3,
        input logic [1:0]  off,
        input logic [31:0] word
    );
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b100:  load_extract = {24'h0, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b101:  load_extract = {16'h0, h};
            default: load_extract = word;
        endcase
    endfunction

    // Decode the incoming op: start, alignment and whether it is accepted.
    always_comb begin
        start = valid & (mem_read | mem_write);
        case (funct3)
            3'b000, 3'b100: aligned = 1'b1;
            3'b001, 3'b101: aligned = ~addr[0];
            default:        aligned = (addr[1:0] == 2'b00);
        endcase
        busy        = (state == S_BUSY);
        accept      = (state == S_IDLE) & start & aligned;
        timeout_hit = busy & ~dmem_ack & (tmo_cnt == TMO_LAST);
        stall       = accept | (busy & ~dmem_ack & ~timeout_hit);
    end

    // Byte enables and lane replication for stores; loads drive neither.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        we_nxt    = mem_write & ~mem_read;
        wstrb_nxt = 4'b0000;
        wdata_nxt = 32'h0;
        if (we_nxt) begin
            case (funct3[1:0])
                2'b00: begin
                    wstrb_nxt = 4'b0001 << addr[1:0];
                    wdata_nxt = {4{store_data[7:0]}};
                end
                2'b01: begin
                    wstrb_nxt = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_nxt = {2{store_data[15:0]}};
                end
                default: begin
                    wstrb_nxt = 4'b1111;
                    wdata_nxt = store_data;
                end
            endcase
        end
    end

    // Next-state logic: leave IDLE on an aligned start, leave BUSY on ack or abort.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_BUSY;
            S_BUSY: if (dmem_ack || timeout_hit) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the edge.
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Transaction context, timeout counter, load result and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt     <= 16'h0;
            lat_we      <= 1'b0;
            lat_addr    <= 32'h0;
            lat_wdata   <= 32'h0;
            lat_wstrb   <= 4'b0000;
            lat_funct3  <= 3'b000;
            lat_off     <= 2'b00;
            memory_data <= 32'h0;
            resp_valid  <= 1'b0;
            misaligned  <= 1'b0;
            bus_error   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        tmo_cnt    <= 16'h0;
                        lat_we     <= we_nxt;
                        lat_addr   <= {addr[31:2], 2'b00};
                        lat_wdata  <= wdata_nxt;
                        lat_wstrb  <= wstrb_nxt;
                        lat_funct3 <= funct3;
                        lat_off    <= addr[1:0];
                    end else if (start) begin
                        misaligned <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (dmem_ack) begin
                        resp_valid <= 1'b1;
                        if (!lat_we)
                            memory_data <= load_extract(lat_funct3, lat_off, dmem_rdata);
                    end else if (timeout_hit) begin
                        memory_data <= 32'h0;
                        bus_error   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'h1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus outputs carry the captured context only while a request is open.
    always_comb begin
        dmem_req   = busy;
        dmem_we    = busy & lat_we;
        dmem_addr  = busy ? lat_addr  : 32'h0;
        dmem_wdata = busy ? lat_wdata : 32'h0;
        dmem_wstrb = busy ? lat_wstrb : 4'b0000;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit: takes the load/store operation leaving the execute stage and runs one request/acknowledge transaction on the data-memory bus. For loads it aligns and sign- or zero-extends the returned word into `memory_data`, the operand the writeback mux selects with `wb_sel = 2'b01`. It stalls the pipeline until the transaction ends and flags misaligned accesses and bus timeouts.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255 — maximum `dmem_ack` wait in BUSY before abort; range 1..65535.

Ports:
- `clk` input 1 — single clock; all state on rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `valid` input 1 — execute-stage op present this cycle.
- `mem_read` input 1 — op is a load.
- `mem_write` input 1 — op is a store; `mem_read` and `mem_write` both high is treated as a load.
- `funct3` input 3 — 000 B, 001 H, 010 W, 100 BU, 101 HU. Stores use 000/001/010 only.
- `addr` input 32 — byte address (ALU result).
- `store_data` input 32 — rs2 value.
- `dmem_req` output 1 — bus request, held until ack.
- `dmem_we` output 1 — 1 = write.
- `dmem_addr` output 32 — `{addr[31:2],2'b00}`.
- `dmem_wdata` output 32 — store data replicated to the lanes.
- `dmem_wstrb` output 4 — byte enables; 0000 for reads.
- `dmem_ack` input 1 — transaction complete; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata` input 32 — read word.
- `memory_data` output 32 — aligned and extended load result, registered.
- `resp_valid` output 1 — one-cycle pulse: `memory_data` updated.
- `stall` output 1 — combinational; hold the upstream pipeline.
- `misaligned` output 1 — one-cycle pulse, access rejected.
- `bus_error` output 1 — one-cycle pulse, timeout abort.

## Operation
- **Start condition:** `start = valid & (mem_read | mem_write)`.
- **Alignment:** H/HU/SH need `addr[0]=0`; W/SW need `addr[1:0]=00`. Any other `funct3` is treated as W.
- **States:** IDLE and BUSY.
  - IDLE, `start` and aligned → BUSY. Latch `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_wstrb`, `funct3`, `addr[1:0]`. Clear the timeout counter.
  - IDLE, `start` and misaligned → stay IDLE. Pulse `misaligned` next cycle. No bus request. `memory_data` unchanged.
  - BUSY, `dmem_ack` → IDLE.
    - Load: `memory_data` ← extracted value, pulse `resp_valid` next cycle.
    - Store: pulse `resp_valid` next cycle; `memory_data` unchanged.
  - BUSY, no ack, counter = `TIMEOUT_CYCLES`-1 → IDLE. `memory_data` ← 0, pulse `bus_error` next cycle. A late ack arriving in IDLE is ignored.
  - BUSY, no ack otherwise → counter +1.
- **Bus outputs:** `dmem_req` = (state == BUSY). Other bus outputs hold their latched values throughout BUSY and are 0 in IDLE.
- **Stores:**
  - SB: wstrb = `4'b0001 << addr[1:0]`, wdata = `{4{store_data[7:0]}}`.
  - SH: wstrb = `addr[1] ? 1100 : 0011`, wdata = `{2{store_data[15:0]}}`.
  - SW: wstrb = 1111, wdata = `store_data`.
- **Loads:**
  - Byte = `rdata[8*addr[1:0] +: 8]`; half = `rdata[16*addr[1] +: 16]`.
  - B/H sign-extend, BU/HU zero-extend, W takes the full word.
- **Stall:** `stall = (IDLE & start & aligned) | (BUSY & ~dmem_ack & ~timeout_hit)`. It deasserts in the ack/abort cycle, so the pipeline advances on that edge.
- **Reset:** state IDLE, counter 0, all outputs 0 (`memory_data` = 0). This holds mid-transaction too: `dmem_req` drops the cycle after the reset edge, and the pending op is discarded without a pulse.
- **Back-to-back:** an op arriving in the cycle after return to IDLE is accepted normally. There is no idle bubble.

## Timing
- Cycle 0: IDLE, `start`, `stall`=1.
- Cycle 1: BUSY, `dmem_req`=1.
- Ack in cycle k≥1 → cycle k+1: IDLE, `resp_valid`=1, `memory_data` valid.
- Minimum latency 2 cycles from accept to `resp_valid`. `stall` is high in cycles 0..k-1.
- Misaligned: `stall` stays 0 and `misaligned` pulses in cycle 1.
- Timeout: BUSY lasts exactly `TIMEOUT_CYCLES` cycles; `bus_error` pulses on the next cycle.
- `resp_valid`, `misaligned` and `bus_error` are mutually exclusive.

## Test plan
- **LW:** addr 0x100, ack on cycle 3, rdata 0xDEADBEEF → `dmem_addr`=0x100, `wstrb`=0000, `memory_data`=0xDEADBEEF, `resp_valid` in cycle 4, `stall` high in cycles 0–2.
- **Byte loads:** rdata 0x80FF7F01, immediate ack.
  - LB at addr offsets 0..3 → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
  - LBU at offset 3 → 0x00000080.
  - LH at offset 2 → 0xFFFF80FF.
- **Stores:**
  - SB addr 0x203, store_data 0x12345678 → `wstrb`=1000, `wdata`=0x78787878, `dmem_we`=1.
  - SH addr 0x202 → `wstrb`=1100, `wdata`=0x56785678.
- **Misaligned:** LW addr 0x102 → no `dmem_req`, `stall`=0, `misaligned` pulse in cycle 1, `memory_data` unchanged.
- **Timeout:** `TIMEOUT_CYCLES`=4, no ack → `dmem_req` high for exactly 4 cycles, `bus_error` pulse, `memory_data`=0. A later stray ack causes no `resp_valid`.
- **Reset and back-to-back:**
  - Assert `rst` in cycle 2 of a pending load → all outputs 0 the next cycle, no `resp_valid`.
  - Two loads back-to-back with ack in cycle 1 each → two `resp_valid` pulses 2 cycles apart, correct data each.
